// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host write port and transmitter handshake for uart_tx_feeder
interface uart_tx_feeder_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          newd;
  logic [7:0]    tx_data;
  logic          donetx;
  logic          busy;

  modport master (
    output wr_en, wr_data, ovf_clr, donetx,
    input  full, empty, count, overflow, newd, tx_data, busy
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, donetx,
    output full, empty, count, overflow, newd, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and newd/donetx sequencer feeding a UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_feeder_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          newd_q;
  logic [7:0]    tx_data_q;
  logic          donetx_q;
  logic          full, empty, push, drop, pop, rise;

  // count never exceeds DEPTH, so its MSB alone marks a full FIFO
  assign full  = count_q[AW];
  assign empty = (count_q == '0);
  assign push  = bus.wr_en && !full;
  assign drop  = bus.wr_en && full;
  assign pop   = (state_q == IDLE) && !empty && !bus.donetx;
  assign rise  = bus.donetx && !donetx_q;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  // GAP waits for donetx to drop so the transmitter sees newd low when it re-enters idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      newd_q    <= 1'b0;
      tx_data_q <= 8'h00;
      donetx_q  <= 1'b0;
    end else begin
      donetx_q <= bus.donetx;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q <= mem[rd_ptr_q];
            newd_q    <= 1'b1;
            state_q   <= SEND;
          end else begin
            newd_q <= 1'b0;
          end
        end
        SEND: begin
          if (rise) begin
            newd_q  <= 1'b0;
            state_q <= GAP;
          end
        end
        GAP: begin
          newd_q <= 1'b0;
          if (!bus.donetx) state_q <= IDLE;
        end
        default: begin
          newd_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.newd     = newd_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b1;
  logic resp_done = 1'b0;
  logic force_done = 1'b0;
  int   resp_delay = 200;
  int   resp_hold = 1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   dup_viol = 0;
  int   max_cnt;
  int   full_seen;
  logic newd_prev = 1'b0;
  logic [7:0] rx_q[$];

  uart_tx_feeder_if #(.AW(4)) bus ();

  uart_tx_feeder #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.donetx = resp_done | force_done;

  always #5 clk = ~clk;

  // transmitter stand-in: latch the presented byte, then pulse donetx
  initial begin
    forever begin
      @(negedge clk);
      if (!stall && !rst && bus.newd) begin
        rx_q.push_back(bus.tx_data);
        repeat (resp_delay) @(negedge clk);
        resp_done = 1'b1;
        repeat (resp_hold) @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.newd && !newd_prev && bus.donetx) dup_viol++;
      newd_prev = bus.newd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      step();
      k++;
    end
    chk("idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    repeat (2) step();
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_newd", {31'd0, bus.newd}, 32'd0);
    chk("rst_txdata", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    // 1: single byte latency and slow completion
    stall = 1'b0;
    repeat (10) step();
    wr(8'hA5);
    chk("t1_count_after_wr", {27'd0, bus.count}, 32'd1);
    chk("t1_newd_not_yet", {31'd0, bus.newd}, 32'd0);
    step();
    chk("t1_newd", {31'd0, bus.newd}, 32'd1);
    chk("t1_txdata", {24'd0, bus.tx_data}, 32'hA5);
    chk("t1_count_popped", {27'd0, bus.count}, 32'd0);
    for (int k = 0; k < 400 && !bus.donetx; k++) step();
    chk("t1_donetx_seen", {31'd0, bus.donetx}, 32'd1);
    chk("t1_newd_low", {31'd0, bus.newd}, 32'd0);
    chk("t1_gap_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("t1_back_idle", {31'd0, bus.busy}, 32'd0);
    chk("t1_rx", {24'd0, rx_q[0]}, 32'hA5);

    // 2: sixteen bytes with the transmitter stalled
    stall = 1'b1;
    resp_delay = 3;
    rx_q.delete();
    max_cnt = 0;
    full_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (bus.full) full_seen = 1;
    end
    chk("t2_peak", max_cnt, 15);
    chk("t2_full_seen", full_seen, 0);
    chk("t2_count", {27'd0, bus.count}, 32'd15);
    chk("t2_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("t2_first", {24'd0, bus.tx_data}, 32'h01);
    stall = 1'b0;
    wait_rx(16, 1000);
    wait_idle(100);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("t2_order", {24'd0, rx_q[i]}, i + 1);

    // 3: overflow with eighteen writes, set-over-clear priority
    stall = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 18; i++) wr(8'h20 + 8'(i));
    chk("t3_full", {31'd0, bus.full}, 32'd1);
    chk("t3_count", {27'd0, bus.count}, 32'd16);
    chk("t3_ovf", {31'd0, bus.overflow}, 32'd1);
    bus.ovf_clr = 1'b1;
    wr(8'h99);
    chk("t3_set_wins", {31'd0, bus.overflow}, 32'd1);
    step();
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'd0, bus.overflow}, 32'd0);
    stall = 1'b0;
    wait_rx(17, 2000);
    wait_idle(100);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk("t3_order", {24'd0, rx_q[i]}, 32'h20 + i);

    // 4: long donetx pulse, then a pop deferred by a high donetx level
    resp_hold = 3;
    rx_q.delete();
    wr(8'h41);
    wr(8'h42);
    wait_rx(2, 400);
    wait_idle(100);
    repeat (10) step();
    chk("t4_no_dup", rx_q.size(), 2);
    chk("t4_b0", {24'd0, rx_q[0]}, 32'h41);
    chk("t4_b1", {24'd0, rx_q[1]}, 32'h42);
    chk("t4_newd_vs_donetx", dup_viol, 0);
    stall = 1'b1;
    force_done = 1'b1;
    rx_q.delete();
    wr(8'h55);
    repeat (3) step();
    chk("t4_deferred_newd", {31'd0, bus.newd}, 32'd0);
    chk("t4_deferred_count", {27'd0, bus.count}, 32'd1);
    force_done = 1'b0;
    step();
    chk("t4_pop_newd", {31'd0, bus.newd}, 32'd1);
    chk("t4_pop_data", {24'd0, bus.tx_data}, 32'h55);
    chk("t4_pop_count", {27'd0, bus.count}, 32'd0);
    stall = 1'b0;
    wait_rx(1, 200);
    chk("t4_rx55", {24'd0, rx_q[0]}, 32'h55);
    wait_idle(100);

    // 5: reset in SEND with bytes queued
    resp_hold = 1;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'h61 + 8'(i));
    chk("t5_queued", {27'd0, bus.count}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_newd", {31'd0, bus.newd}, 32'd0);
    chk("t5_count", {27'd0, bus.count}, 32'd0);
    chk("t5_empty", {31'd0, bus.empty}, 32'd1);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    rx_q.delete();
    stall = 1'b0;
    wr(8'h3C);
    wait_rx(1, 200);
    chk("t5_rx3c", {24'd0, rx_q[0]}, 32'h3C);
    wait_idle(100);

    // 6: write and pop in one cycle, then pointer wrap
    stall = 1'b1;
    force_done = 1'b1;
    step();
    wr(8'h70);
    chk("t6_count1", {27'd0, bus.count}, 32'd1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h71;
    force_done = 1'b0;
    step();
    bus.wr_en = 1'b0;
    chk("t6_count_same", {27'd0, bus.count}, 32'd1);
    chk("t6_newd", {31'd0, bus.newd}, 32'd1);
    chk("t6_data", {24'd0, bus.tx_data}, 32'h70);
    rx_q.delete();
    resp_delay = 1;
    stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 10; i++) wr(8'h80 + 8'(c * 10 + i));
      wait_rx(2 + (c + 1) * 10, 1000);
    end
    wait_idle(100);
    chk("t6_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("t6_b70", {24'd0, rx_q[0]}, 32'h70);
    chk("t6_b71", {24'd0, rx_q[1]}, 32'h71);
    for (int i = 0; i < 40 && i + 2 < rx_q.size(); i++) chk("t6_wrap_order", {24'd0, rx_q[i + 2]}, 32'h80 + i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
